// File: rtl/field_sequencer_if.sv
// Bundle of the sequencer's button, UART, SPI and actuator/status signals.
`timescale 1ns/1ps
interface field_sequencer_if #(
  parameter int NCH = 4,
  parameter int DW  = 8
);
  logic           bt_start;
  logic           bt_setting;
  logic [7:0]     rx_data;
  logic           rx_done;
  logic [DW-1:0]  sensor_data;
  logic           spi_done;
  logic [NCH-1:0] act_out;
  logic [DW-1:0]  led_out;
  logic           morning_signal;
  logic           after_signal;
  logic           day_done;
  logic           cmd_err;

  // Upstream side: buttons, UART RX, SPI master, and the observer of outputs.
  modport master (
    output bt_start, bt_setting, rx_data, rx_done, sensor_data, spi_done,
    input  act_out, led_out, morning_signal, after_signal, day_done, cmd_err
  );

  // Sequencer side.
  modport slave (
    input  bt_start, bt_setting, rx_data, rx_done, sensor_data, spi_done,
    output act_out, led_out, morning_signal, after_signal, day_done, cmd_err
  );
endinterface

// File: rtl/field_sequencer.sv
// Day-cycle sequencer: IDLE -> WAIT_SENSE -> MORNING -> AFTERNOON -> DONE,
// driving NCH actuator enables gated by a UART-set mask and a sensor inhibit.
`timescale 1ns/1ps

// One actuator channel: even channels run in the morning, odd in the afternoon.
module field_sequencer_lane #(
  parameter bit ODD = 1'b0
) (
  input  logic clk,
  input  logic n_rst,
  input  logic en_i,
  input  logic morning_i,
  input  logic after_i,
  output logic act_o
);
  logic act_q, act_d;

  assign act_d = en_i & ((morning_i & ~ODD) | (after_i & ODD));

  // Output register: enable follows state/mask/inhibit one cycle later.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) act_q <= 1'b0;
    else        act_q <= act_d;
  end

  assign act_o = act_q;
endmodule

module field_sequencer #(
  parameter int            NCH         = 4,
  parameter int            DW          = 8,
  parameter int            PHASE_TICKS = 1000,
  parameter logic [DW-1:0] THRESH      = DW'(8'h80)
) (
  input logic              clk,
  input logic              n_rst,
  field_sequencer_if.slave bus
);
  localparam int            CW   = $clog2(PHASE_TICKS);
  localparam logic [CW-1:0] LAST = CW'(PHASE_TICKS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_SENSE, S_MORNING, S_AFTERNOON, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NCH-1:0]  mask_q, mask_d;
  logic [DW-1:0]   sample_q, sample_d;
  logic            err_q, err_d;
  logic            inhibit;
  logic [NCH-1:0]  act;

  // State and phase-counter register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state; the counter is zero outside the phases and on each phase entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    unique case (state_q)
      S_IDLE:       if (bus.bt_start) state_d = S_WAIT_SENSE;
      S_WAIT_SENSE: if (bus.spi_done) state_d = S_MORNING;
      S_MORNING: begin
        if (cnt_q == LAST) state_d = S_AFTERNOON;
        else               cnt_d   = cnt_q + CW'(1);
      end
      S_AFTERNOON: begin
        if (cnt_q == LAST) state_d = S_DONE;
        else               cnt_d   = cnt_q + CW'(1);
      end
      S_DONE:       state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
    // Abort wins over start and over phase expiry.
    if (bus.bt_setting) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  // Command decode: digit toggles a channel, '0' clears, 'A' sets, else error.
  always_comb begin
    mask_d = mask_q;
    err_d  = 1'b0;
    if (bus.rx_done) begin
      if (bus.rx_data == 8'h30) begin
        mask_d = '0;
      end else if (bus.rx_data == 8'h41) begin
        mask_d = '1;
      end else begin
        err_d = 1'b1;
        for (int i = 0; i < NCH; i++) begin
          if (bus.rx_data == 8'(8'h31 + i)) begin
            mask_d[i] = ~mask_q[i];
            err_d     = 1'b0;
          end
        end
      end
    end
  end

  // Sensor sample latches on every SPI strobe regardless of state.
  assign sample_d = bus.spi_done ? bus.sensor_data : sample_q;

  // Mask, sensor sample and error-pulse registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      mask_q   <= '0;
      sample_q <= '0;
      err_q    <= 1'b0;
    end else begin
      mask_q   <= mask_d;
      sample_q <= sample_d;
      err_q    <= err_d;
    end
  end

  assign inhibit = (sample_q >= THRESH);

  for (genvar i = 0; i < NCH; i++) begin : g_lane
    field_sequencer_lane #(.ODD((i % 2) == 1)) u_lane (
      .clk       (clk),
      .n_rst     (n_rst),
      .en_i      (mask_q[i] & ~inhibit),
      .morning_i (state_q == S_MORNING),
      .after_i   (state_q == S_AFTERNOON),
      .act_o     (act[i])
    );
  end

  assign bus.act_out        = act;
  assign bus.led_out        = sample_q;
  assign bus.morning_signal = (state_q == S_MORNING);
  assign bus.after_signal   = (state_q == S_AFTERNOON);
  assign bus.day_done       = (state_q == S_DONE);
  assign bus.cmd_err        = err_q;
endmodule

// File: tb/tb_field_sequencer.sv
// Bench for field_sequencer: vector table plus day/inhibit/abort/reset sequences.
`timescale 1ns/1ps
module tb_field_sequencer;
  localparam int NCH = 4;
  localparam int DW  = 8;
  localparam int PT  = 10;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  field_sequencer_if #(.NCH(NCH), .DW(DW)) bus ();

  field_sequencer #(.NCH(NCH), .DW(DW), .PHASE_TICKS(PT), .THRESH(8'h80)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  typedef struct {
    logic       st, se, rv;
    logic [7:0] rx;
    logic       sv;
    logic [7:0] sd;
    logic [3:0] act;
    logic       m, a, dd, err, ca;
  } vec_t;

  typedef struct {
    logic [15:0] v;
    logic [15:0] care;
    string       nm;
  } exp_t;

  exp_t       sbq[$];
  int         total = 0;
  int         bad   = 0;
  logic [7:0] led_exp = 8'h00;

  function automatic vec_t V(logic st, logic se, logic rv, logic [7:0] rx,
                             logic sv, logic [7:0] sd, logic [3:0] act,
                             logic m, logic a, logic dd, logic err, logic ca = 1'b1);
    vec_t r;
    r.st = st; r.se = se; r.rv = rv; r.rx = rx; r.sv = sv; r.sd = sd;
    r.act = act; r.m = m; r.a = a; r.dd = dd; r.err = err; r.ca = ca;
    return r;
  endfunction

  function automatic logic [15:0] outw();
    return {bus.act_out, bus.led_out, bus.morning_signal, bus.after_signal,
            bus.day_done, bus.cmd_err};
  endfunction

  task automatic cmp(input logic [15:0] ev, input logic [15:0] care, input string nm);
    logic [15:0] got;
    got = outw();
    total++;
    if ((got & care) !== (ev & care)) begin
      bad++;
      $display("FAIL %s: got act/led/m/a/dd/err=%h want %h (care %h) t=%0t",
               nm, got, ev, care, $time);
    end
  endtask

  task automatic clear_in();
    bus.bt_start = 1'b0; bus.bt_setting = 1'b0;
    bus.rx_done = 1'b0;  bus.rx_data = 8'h00;
    bus.spi_done = 1'b0; bus.sensor_data = 8'h00;
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare after the edge.
  task automatic step(input vec_t v, input string nm);
    exp_t e;
    bus.bt_start = v.st; bus.bt_setting = v.se;
    bus.rx_done = v.rv;  bus.rx_data = v.rx;
    bus.spi_done = v.sv; bus.sensor_data = v.sd;
    if (v.sv) led_exp = v.sd;
    e.v    = {v.act, led_exp, v.m, v.a, v.dd, v.err};
    e.care = v.ca ? 16'hFFFF : 16'h0FFF;
    e.nm   = nm;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    clear_in();
    if (sbq.size() == 0) begin
      total++; bad++;
      $display("FAIL %s: scoreboard empty", nm);
    end else begin
      e = sbq.pop_front();
      cmp(e.v, e.care, e.nm);
    end
  endtask

  task automatic idle(input logic [3:0] act, input logic m, input logic a,
                      input logic dd, input string nm);
    step(V(0, 0, 0, 8'h00, 0, 8'h00, act, m, a, dd, 0), nm);
  endtask

  // Full day from WAIT_SENSE with the given mask and a low sensor reading.
  task automatic run_day(input logic [3:0] mask);
    logic [3:0] e, o;
    e = mask & 4'b0101;
    o = mask & 4'b1010;
    step(V(0, 0, 0, 8'h00, 1, 8'h20, 4'b0000, 1, 0, 0, 0), "morning_entry");
    repeat (PT - 1) idle(e, 1, 0, 0, "morning_act");
    idle(e, 0, 1, 0, "afternoon_entry");
    repeat (PT - 1) idle(o, 0, 1, 0, "afternoon_act");
    idle(o, 0, 0, 1, "day_done");
    idle(4'b0000, 0, 0, 0, "back_idle");
  endtask

  vec_t tbl[4];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_in();
    // Command vectors from reset: set channel 0, then two illegal bytes.
    tbl[0] = V(0, 0, 1, 8'h31, 0, 8'h00, 4'b0000, 0, 0, 0, 0);
    tbl[1] = V(0, 0, 1, 8'h35, 0, 8'h00, 4'b0000, 0, 0, 0, 1);
    tbl[2] = V(0, 0, 1, 8'h7A, 0, 8'h00, 4'b0000, 0, 0, 0, 1);
    tbl[3] = V(1, 0, 0, 8'h00, 0, 8'h00, 4'b0000, 0, 0, 0, 0);

    #12;
    cmp(16'h0000, 16'hFFFF, "reset_state");
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    idle(4'b0000, 0, 0, 0, "post_reset_idle");

    for (int i = 0; i < 4; i++) step(tbl[i], $sformatf("table[%0d]", i));
    // Mask 0001 must survive the illegal bytes.
    run_day(4'b0001);

    // All channels on.
    step(V(0, 0, 1, 8'h41, 0, 8'h00, 4'b0000, 0, 0, 0, 0), "cmd_all");
    step(V(1, 0, 0, 8'h00, 0, 8'h00, 4'b0000, 0, 0, 0, 0), "start2");
    run_day(4'b1111);

    // Sensor inhibit mid-morning and recovery.
    step(V(1, 0, 0, 8'h00, 0, 8'h00, 4'b0000, 0, 0, 0, 0), "start3");
    step(V(0, 0, 0, 8'h00, 1, 8'h20, 4'b0000, 1, 0, 0, 0), "inh_morning");
    idle(4'b0101, 1, 0, 0, "inh_pre");
    step(V(0, 0, 0, 8'h00, 1, 8'h90, 4'b0101, 1, 0, 0, 0), "inh_sample_hi");
    idle(4'b0000, 1, 0, 0, "inh_active");
    step(V(0, 0, 0, 8'h00, 1, 8'h7F, 4'b0000, 1, 0, 0, 0), "inh_sample_lo");
    idle(4'b0101, 1, 0, 0, "inh_released");
    step(V(0, 1, 0, 8'h00, 0, 8'h00, 4'b0000, 0, 0, 0, 0, 0), "abort_morning");
    idle(4'b0000, 0, 0, 0, "abort_morning_act");

    // Abort at cycle 5 of AFTERNOON.
    step(V(1, 0, 0, 8'h00, 0, 8'h00, 4'b0000, 0, 0, 0, 0), "start4");
    step(V(0, 0, 0, 8'h00, 1, 8'h20, 4'b0000, 1, 0, 0, 0), "ab_morning");
    repeat (PT - 1) idle(4'b0101, 1, 0, 0, "ab_morning_act");
    idle(4'b0101, 0, 1, 0, "ab_afternoon");
    repeat (4) idle(4'b1010, 0, 1, 0, "ab_afternoon_act");
    step(V(0, 1, 0, 8'h00, 0, 8'h00, 4'b0000, 0, 0, 0, 0, 0), "ab_idle_flags");
    repeat (PT + 2) idle(4'b0000, 0, 0, 0, "ab_no_day_done");
    step(V(1, 0, 0, 8'h00, 0, 8'h00, 4'b0000, 0, 0, 0, 0), "restart");
    idle(4'b0000, 0, 0, 0, "restart_wait");
    step(V(0, 0, 0, 8'h00, 1, 8'h20, 4'b0000, 1, 0, 0, 0), "restart_morning");
    idle(4'b0101, 1, 0, 0, "restart_act");

    // Asynchronous reset mid-MORNING.
    idle(4'b0101, 1, 0, 0, "pre_reset");
    n_rst = 1'b0;
    #1;
    cmp(16'h0000, 16'hFFFF, "async_reset");
    led_exp = 8'h00;
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    repeat (3) idle(4'b0000, 0, 0, 0, "reset_stays_idle");
    step(V(0, 0, 0, 8'h00, 1, 8'h20, 4'b0000, 0, 0, 0, 0), "spi_in_idle");
    step(V(1, 0, 0, 8'h00, 0, 8'h00, 4'b0000, 0, 0, 0, 0), "start5");
    step(V(0, 0, 0, 8'h00, 1, 8'h10, 4'b0000, 1, 0, 0, 0), "post_reset_morning");
    repeat (3) idle(4'b0000, 1, 0, 0, "mask_cleared");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
